mmio_pwm_led: RTL and testbench

- Memory-mapped LED/RGB PWM peripheral: the responder on the core's data-memory bus.
- The core issues load/store requests to a fixed address window; this block decodes them, holds duty/prescale registers and drives the board LED and RGB pins.
- Sits beside data RAM inside top; the LED, RGB_R, RGB_G and RGB_B top-level pins come from here.

---
 rtl/mmio_pwm_led.sv | 215 +++++++++++++++++++++
 tb/tb_mmio_pwm_led.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_pwm_led.sv
// mmio_pwm_led -- memory-mapped LED / RGB PWM peripheral.
//
// Responder on the core's data-memory bus. It decodes a 16-byte register
// window at BASE_ADDR, holds the duty and prescale registers and drives the
// board LED and RGB pins with 8-bit PWM (256 ticks per frame).
//
// Register map (byte offset from BASE_ADDR, mem_addr[1:0] ignored):
//   0x0 LED_DUTY  [7:0]                   rw
//   0x4 RGB_DUTY  R[7:0] G[15:8] B[23:16] rw
//   0x8 PRESCALE  [15:0]                  rw
//   0xC FRAME     frame counter           ro
//
// Optional build macro MMIO_PWM_FRAME_IRQ_EN: adds the irq output, a sticky
// frame-wrap flag cleared by any store to 0xC and read back as FRAME[31]
// (the counter then shrinks to 31 bits). Without it, stores to 0xC are
// ignored and FRAME is a full 32-bit counter.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   mem_addr/we/wstrb/wdata  store request (single-cycle qualifier mem_we)
//   mem_re                load request (single-cycle qualifier)
//   mem_rdata/mem_rvalid  load response, one cycle after mem_re
//   LED                   user LED PWM, active-high
//   RGB_R/G/B             RGB PWM, inverted when RGB_ACTIVE_LOW
//   irq                   frame-wrap interrupt (macro builds only)

module mmio_pwm_led #(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FF00,
    parameter bit          RGB_ACTIVE_LOW = 1'b1,
    parameter logic [15:0] PRESCALE_RST   = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
`ifdef MMIO_PWM_FRAME_IRQ_EN
    output logic        irq,
`endif
    output logic        LED,
    output logic        RGB_R,
    output logic        RGB_G,
    output logic        RGB_B
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] off;
    logic       wr;
    logic       rd;

    assign sel = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign off = mem_addr[3:2];
    assign wr  = mem_we && sel;
    assign rd  = mem_re && sel;

    // Byte address bits and the top write byte never reach any register.
    logic unused_ok;
    assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:24], mem_wstrb[3]};

    // ------------------------------------------------------------------
    // Programmed registers
    // ------------------------------------------------------------------
    logic [7:0]  led_duty;
    logic [23:0] rgb_duty;
    logic [15:0] prescale;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_duty <= '0;
            rgb_duty <= '0;
            prescale <= PRESCALE_RST;
        end else if (wr) begin
            case (off)
                2'd0: if (mem_wstrb[0]) led_duty <= mem_wdata[7:0];
                2'd1: begin
                    for (int i = 0; i < 3; i++)
                        if (mem_wstrb[i]) rgb_duty[8*i +: 8] <= mem_wdata[8*i +: 8];
                end
                2'd2: begin
                    for (int i = 0; i < 2; i++)
                        if (mem_wstrb[i]) prescale[8*i +: 8] <= mem_wdata[8*i +: 8];
                end
                default: ; // FRAME is read-only
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and PWM counter
    // ------------------------------------------------------------------
    // Using >= rather than == makes a prescale value written below the
    // current count wrap immediately instead of running to 65535 first.
    logic [15:0] pcnt;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        wrap;

    assign tick = (pcnt >= prescale);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt    <= '0;
            pwm_cnt <= '0;
        end else begin
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Shadow duties: reloaded only at the frame wrap so software updates
    // never produce a glitched partial frame.
    // ------------------------------------------------------------------
    logic [7:0]  sh_led;
    logic [23:0] sh_rgb;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_led <= '0;
            sh_rgb <= '0;
        end else if (wrap) begin
            sh_led <= led_duty;
            sh_rgb <= rgb_duty;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter (and optional sticky wrap flag)
    // ------------------------------------------------------------------
    logic [31:0] frame_val;

`ifdef MMIO_PWM_FRAME_IRQ_EN
    logic [30:0] frame_cnt;
    logic        frame_flag;
    logic        frame_clr;

    assign frame_clr = wr && (off == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= '0;
            frame_flag <= 1'b0;
        end else begin
            if (wrap) frame_cnt <= frame_cnt + 31'd1;
            // set has priority over a coincident clear
            if (wrap)           frame_flag <= 1'b1;
            else if (frame_clr) frame_flag <= 1'b0;
        end
    end

    assign frame_val = {frame_flag, frame_cnt};
    assign irq       = frame_flag;
`else
    logic [31:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset)     frame_cnt <= '0;
        else if (wrap) frame_cnt <= frame_cnt + 32'd1;
    end

    assign frame_val = frame_cnt;
`endif

    // ------------------------------------------------------------------
    // Read path: registered, so a same-cycle store is not yet visible and
    // the read returns the pre-write value.
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (off)
            2'd0:    rd_mux = {24'd0, led_duty};
            2'd1:    rd_mux = {8'd0, rgb_duty};
            2'd2:    rd_mux = {16'd0, prescale};
            default: rd_mux = frame_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata  <= '0;
            mem_rvalid <= 1'b0;
        end else begin
            mem_rvalid <= rd;
            if (rd) mem_rdata <= rd_mux;
        end
    end

    // ------------------------------------------------------------------
    // Registered PWM outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            LED   <= 1'b0;
            RGB_R <= RGB_ACTIVE_LOW;
            RGB_G <= RGB_ACTIVE_LOW;
            RGB_B <= RGB_ACTIVE_LOW;
        end else begin
            LED   <= (pwm_cnt < sh_led);
            RGB_R <= (pwm_cnt < sh_rgb[7:0])   ^ RGB_ACTIVE_LOW;
            RGB_G <= (pwm_cnt < sh_rgb[15:8])  ^ RGB_ACTIVE_LOW;
            RGB_B <= (pwm_cnt < sh_rgb[23:16]) ^ RGB_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_mmio_pwm_led.sv
// Directed self-checking bench for mmio_pwm_led (default parameters).
module tb_mmio_pwm_led;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        LED, RGB_R, RGB_G, RGB_B;
`ifdef MMIO_PWM_FRAME_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;
    int since_rst = 0;   // cycles since reset release == pwm_cnt while PRESCALE=0

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) since_rst <= 0;
        else       since_rst <= since_rst + 1;
    end

    mmio_pwm_led dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
`ifdef MMIO_PWM_FRAME_IRQ_EN
        .irq(irq),
`endif
        .LED(LED), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_we = 1'b1;
        cyc();
        mem_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        mem_addr = a; mem_re = 1'b1;
        cyc();
        v = mem_rvalid; d = mem_rdata;
        mem_re = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        checks++;
        if ({LED, RGB_R, RGB_G, RGB_B, mem_rvalid} !== 5'b01110 || mem_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outs: led/r/g/b/rvalid=%b rdata=%h want 01110 00000000",
                     {LED, RGB_R, RGB_G, RGB_B, mem_rvalid}, mem_rdata);
        end
        bus_read(BASE + 32'h4, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++; $display("FAIL reset_read_rgb: v=%b d=%h want 1 00000000", v, d);
        end
        cyc();
        checks++;
        if (mem_rvalid !== 1'b0) begin
            errors++; $display("FAIL rvalid_pulse: got %b want 0", mem_rvalid);
        end
        // FRAME store before the first wrap: counter stays 0, no flag
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'hC, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            errors++; $display("FAIL frame_ro: v=%b d=%h want 1 00000000", v, d);
        end
    endtask

    task automatic test_rgb();
        logic [31:0] d; logic v;
        int r_lo, g_lo, b_lo;
        bus_write(BASE + 32'h4, 32'h00FF_8040, 4'b0101);
        bus_read(BASE + 32'h4, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h00FF_0040) begin
            errors++; $display("FAIL rgb_strobe: v=%b d=%h want 1 00ff0040", v, d);
        end
        repeat (512) cyc();   // guarantee a frame boundary has loaded the shadows
        r_lo = 0; g_lo = 0; b_lo = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (RGB_R === 1'b0) r_lo++;
            if (RGB_G === 1'b0) g_lo++;
            if (RGB_B === 1'b0) b_lo++;
        end
        checks++;
        if (r_lo != 64) begin errors++; $display("FAIL rgb_r_duty: low %0d want 64", r_lo); end
        checks++;
        if (g_lo != 0) begin errors++; $display("FAIL rgb_g_duty: low %0d want 0", g_lo); end
        checks++;
        if (b_lo != 255) begin errors++; $display("FAIL rgb_b_duty: low %0d want 255", b_lo); end
    endtask

    task automatic test_led_shadow();
        int bad, on, guard;
        guard = 0;
        while ((since_rst % 256) != 9 && guard < 300) begin cyc(); guard++; end
        bus_write(BASE, 32'd128, 4'b0001);   // lands as pwm_cnt goes 9 -> 10
        bad = 0;
        guard = 0;
        while ((since_rst % 256) != 0 && guard < 300) begin
            if (LED !== 1'b0) bad++;
            cyc(); guard++;
        end
        if (LED !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL led_midframe: %0d high samples want 0", bad); end
        on = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (LED === 1'b1) on++;
        end
        checks++;
        if (on != 128) begin errors++; $display("FAIL led_duty128: high %0d want 128", on); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic v;
        bus_write(BASE, 32'h22, 4'b0001);
        mem_addr = BASE; mem_wdata = 32'h55; mem_wstrb = 4'b0001;
        mem_we = 1'b1; mem_re = 1'b1;
        cyc();
        mem_we = 1'b0; mem_re = 1'b0;
        checks++;
        if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h22) begin
            errors++; $display("FAIL rw_collision: v=%b d=%h want 1 00000022", mem_rvalid, mem_rdata);
        end
        bus_read(BASE + 32'h3, d, v);   // byte offset bits ignored
        checks++;
        if (v !== 1'b1 || d !== 32'h55) begin
            errors++; $display("FAIL read_after_write: v=%b d=%h want 1 00000055", v, d);
        end
        bus_write(BASE, 32'hABCD_EF77, 4'hF);
        bus_read(BASE, d, v);
        checks++;
        if (d !== 32'h77) begin errors++; $display("FAIL led_upper_zero: d=%h want 00000077", d); end
        bus_read(BASE + 32'h10, d, v);
        checks++;
        if (v !== 1'b0 || mem_rdata !== 32'h77) begin
            errors++; $display("FAIL unselected_read: v=%b d=%h want 0 00000077", v, mem_rdata);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d, f0, f1; logic v;
        int diff;
        bus_write(BASE + 32'h8, 32'h0000_0003, 4'b0011);
        bus_read(BASE + 32'h8, d, v);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL prescale_rb: d=%h want 00000003", d); end
        bus_read(BASE + 32'hC, f0, v);
        repeat (4095) cyc();
        bus_read(BASE + 32'hC, f1, v);
        diff = int'(f1[30:0]) - int'(f0[30:0]);
        checks++;
        if (diff < 3 || diff > 5) begin
            errors++; $display("FAIL prescale_frames: delta %0d want 4 +-1", diff);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        mem_addr = BASE + 32'h4; mem_re = 1'b1; reset = 1'b1;
        cyc();
        mem_re = 1'b0;
        checks++;
        if ({LED, RGB_R, RGB_G, RGB_B, mem_rvalid} !== 5'b01110 || mem_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outs: led/r/g/b/rvalid=%b rdata=%h want 01110 00000000",
                     {LED, RGB_R, RGB_G, RGB_B, mem_rvalid}, mem_rdata);
        end
        reset = 1'b0;
        bus_read(BASE + 32'h4, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_rgb: d=%h want 00000000", d); end
        bus_read(BASE + 32'h8, d, v);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_prescale: d=%h want 00000000", d); end
    endtask

`ifdef MMIO_PWM_FRAME_IRQ_EN
    task automatic test_irq();
        logic [31:0] d; logic v;
        int guard;
        do_reset();
        guard = 0;
        while (since_rst != 255 && guard < 300) begin cyc(); guard++; end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_pre_wrap: got %b want 0", irq); end
        cyc();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_first_wrap: got %b want 1", irq); end
        bus_write(BASE + 32'hC, 32'd0, 4'hF);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        guard = 0;
        while (since_rst != 511 && guard < 300) begin cyc(); guard++; end
        bus_write(BASE + 32'hC, 32'd0, 4'hF);   // clear coincides with second wrap
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq); end
        bus_read(BASE + 32'hC, d, v);
        checks++;
        if (d !== 32'h8000_0002) begin errors++; $display("FAIL irq_frame_rb: d=%h want 80000002", d); end
    endtask
`else
    task automatic test_frame();
        logic [31:0] d; logic v;
        int guard;
        do_reset();
        guard = 0;
        while (since_rst != 512 && guard < 600) begin cyc(); guard++; end
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'hC, d, v);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL frame_count: d=%h want 00000002", d); end
    endtask
`endif

    initial begin
        mem_addr = '0; mem_we = 1'b0; mem_wstrb = '0; mem_wdata = '0; mem_re = 1'b0;
        do_reset();
        test_reset();
        test_rgb();
        test_led_shadow();
        test_back_to_back();
        test_prescale();
        test_reset_mid();
`ifdef MMIO_PWM_FRAME_IRQ_EN
        test_irq();
`else
        test_frame();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
